vga_timing_monitor: RTL
=======================

// Module: vga_timing_monitor
//
// PURPOSE
// - Passive downstream sink for the AHBVGA video outputs (HSYNC, VSYNC, RGB), one clock domain with the VGA core.
// - Measures line and frame timing and flags deviations from the programmed geometry.
// - Counts frames; optionally accumulates a per-frame pixel checksum for scoreboarding.
// - Used in the VGA bench and for on-chip self-check.
//
// PARAMETERS
// - LINE_CLKS    default 1600  expected HCLK cycles between successive HSYNC falling edges
// - HSYNC_CLKS   default 192   expected HSYNC low width, HCLK cycles
// - FRAME_LINES  default 525   expected lines (HSYNC falls) between successive VSYNC falling edges
// - VSYNC_LINES  default 2     expected VSYNC low width, in lines
//
// PORTS
// - HCLK         in   1   clock, all logic on rising edge
// - HRESET       in   1   synchronous reset, active-high
// - HSYNC        in   1   horizontal sync from VGA core, active-low, synchronous to HCLK
// - VSYNC        in   1   vertical sync from VGA core, active-low, synchronous to HCLK
// - RGB          in   8   pixel data from VGA core
// - ERR_CLR      in   1   one-cycle pulse, clears sticky error flags
// - LOCKED       out  1   high once the first VSYNC falling edge has been seen
// - FRAME_DONE   out  1   one-cycle pulse per completed frame (LOCKED only)
// - H_ERR        out  1   sticky: a measured line period differed from LINE_CLKS
// - HSW_ERR      out  1   sticky: a measured HSYNC low width differed from HSYNC_CLKS
// - V_ERR        out  1   sticky: line count per frame or VSYNC width differed from expected
// - LINE_LEN     out  12  last measured line period, HCLK cycles
// - FRAME_LEN    out  11  last measured lines per frame
// - FRAME_CNT    out  16  completed frames since reset, wraps 0xFFFF -> 0
// - CHECKSUM     out  16  last frame's pixel sum (see CONFIGURATION)
//
// BEHAVIOUR
// - Reset: all outputs 0, state ACQUIRE, all counters 0; sync-edge history registers set to 1.
// - Edge detect: HSYNC/VSYNC registered once; fall = prev 1 & cur 0; rise = prev 0 & cur 1.
// - States: ACQUIRE -> LOCKED on first VSYNC fall; LOCKED held until HRESET (no return to ACQUIRE).
// - clk_cnt: clears to 1 on HSYNC fall, else +1, saturates at 4095.
//   On HSYNC fall (LOCKED): LINE_LEN <= clk_cnt; H_ERR set if clk_cnt != LINE_CLKS.
//   Exception: the first HSYNC fall after lock is not checked (partial line).
// - hsw_cnt: counts HCLK while HSYNC low; on HSYNC rise (LOCKED), HSW_ERR set if != HSYNC_CLKS.
// - line_cnt: +1 per HSYNC fall, saturates at 2047; clears to 0 on VSYNC fall.
//   On VSYNC fall (LOCKED, not the locking edge): FRAME_LEN <= line_cnt; V_ERR set if != FRAME_LINES.
// - Same-cycle VSYNC fall and HSYNC fall: HSYNC fall counted into the closing frame first.
// - VSYNC low width: HSYNC falls counted while VSYNC low; V_ERR set on VSYNC rise if != VSYNC_LINES.
// - FRAME_DONE and FRAME_CNT increment: registered, 1 cycle after each checked VSYNC fall.
// - Latency: LINE_LEN/FRAME_LEN/errors update 1 cycle after the registered edge (2 HCLK after pin edge).
// - ERR_CLR clears H_ERR/HSW_ERR/V_ERR; a new error detected in the same cycle wins (flag stays 1).
// - HRESET mid-frame: everything returns to reset values; re-lock on next VSYNC fall.
// - Only sync pins and RGB are observed; never drives the VGA core.
//
// CONFIGURATION
// - VGA_MON_CHECKSUM_EN defined: 16-bit accumulator adds zero-extended RGB every HCLK where HSYNC=1 and VSYNC=1, mod 2^16.
//   On each checked VSYNC fall, CHECKSUM <= accumulator; accumulator clears the same cycle.
// - Not defined: no accumulator logic; CHECKSUM tied to 16'h0000.
//
// TESTING (bench overrides: LINE_CLKS=20, HSYNC_CLKS=4, FRAME_LINES=10, VSYNC_LINES=2)
// - Reset: HRESET=1 for 3 cycles -> all outputs 0, LOCKED=0.
// - Clean timing, 3 frames -> LOCKED=1 after first VSYNC fall; FRAME_DONE pulses twice; FRAME_CNT=2; LINE_LEN=20, FRAME_LEN=10; no errors.
// - One line stretched to 21 clocks -> H_ERR=1, LINE_LEN=21; ERR_CLR pulse -> H_ERR=0; HSW_ERR/V_ERR stay 0.
// - HSYNC low 5 clocks on one line -> HSW_ERR=1 only. Frame of 9 lines -> V_ERR=1, FRAME_LEN=9.
// - ERR_CLR asserted in same cycle as a bad-line HSYNC fall -> H_ERR remains 1.
// - VGA_MON_CHECKSUM_EN, RGB=8'h01 constant -> CHECKSUM = count of cycles with HSYNC=1 and VSYNC=1 in the frame (e.g. 128).
//   Without the macro -> CHECKSUM=0.

Source files
------------

// File: rtl/vga_timing_monitor_if.sv
// vga_timing_monitor_if: VGA sync/pixel taps and monitor status bundle
interface vga_timing_monitor_if;
    logic        HSYNC;
    logic        VSYNC;
    logic [7:0]  RGB;
    logic        ERR_CLR;
    logic        LOCKED;
    logic        FRAME_DONE;
    logic        H_ERR;
    logic        HSW_ERR;
    logic        V_ERR;
    logic [11:0] LINE_LEN;
    logic [10:0] FRAME_LEN;
    logic [15:0] FRAME_CNT;
    logic [15:0] CHECKSUM;

    modport master (
        output HSYNC, VSYNC, RGB, ERR_CLR,
        input  LOCKED, FRAME_DONE, H_ERR, HSW_ERR, V_ERR,
        input  LINE_LEN, FRAME_LEN, FRAME_CNT, CHECKSUM
    );

    modport slave (
        input  HSYNC, VSYNC, RGB, ERR_CLR,
        output LOCKED, FRAME_DONE, H_ERR, HSW_ERR, V_ERR,
        output LINE_LEN, FRAME_LEN, FRAME_CNT, CHECKSUM
    );
endinterface

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: passive VGA line/frame timing checker; VGA_MON_CHECKSUM_EN adds a per-frame pixel sum
module vga_timing_monitor #(
    parameter int LINE_CLKS   = 1600,
    parameter int HSYNC_CLKS  = 192,
    parameter int FRAME_LINES = 525,
    parameter int VSYNC_LINES = 2
) (
    input logic                  HCLK,
    input logic                  HRESET,
    vga_timing_monitor_if.slave  mon
);
    localparam logic [11:0] LINE_L  = 12'(LINE_CLKS);
    localparam logic [11:0] HSW_L   = 12'(HSYNC_CLKS);
    localparam logic [10:0] FRAME_L = 11'(FRAME_LINES);
    localparam logic [10:0] VSW_L   = 11'(VSYNC_LINES);

    typedef enum logic {ACQUIRE, LOCKED} state_t;
    state_t state_q, state_d;

    logic        hs_q, hs_p_q, vs_q, vs_p_q;
    logic        first_q, first_d;
    logic [11:0] clk_cnt_q, clk_cnt_d;
    logic [11:0] hsw_cnt_q, hsw_cnt_d;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic [10:0] vsw_cnt_q, vsw_cnt_d;
    logic [11:0] line_len_q, line_len_d;
    logic [10:0] frame_len_q, frame_len_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        frame_done_q, frame_done_d;
    logic        h_err_q, h_err_d;
    logic        hsw_err_q, hsw_err_d;
    logic        v_err_q, v_err_d;
    logic        h_fall, h_rise, v_fall, v_rise, locked, h_chk, v_chk;
    logic [10:0] lines_closed;

    assign h_fall = hs_p_q & ~hs_q;
    assign h_rise = ~hs_p_q & hs_q;
    assign v_fall = vs_p_q & ~vs_q;
    assign v_rise = ~vs_p_q & vs_q;
    assign locked = (state_q == LOCKED);
    // the line straddling the lock point is partial, so its period is not judged
    assign h_chk  = locked & h_fall & ~first_q;
    // the locking VSYNC edge opens the first frame; only later edges close one
    assign v_chk  = locked & v_fall;
    // a coincident HSYNC fall belongs to the frame that is closing
    assign lines_closed = (h_fall && line_cnt_q != 11'h7FF) ? line_cnt_q + 11'd1 : line_cnt_q;

    // acquire/lock state: locks on the first VSYNC fall and stays until reset
    always_comb begin
        state_d = state_q;
        if (state_q == ACQUIRE && v_fall) state_d = LOCKED;
    end

    // counters, measurements and sticky error flags
    always_comb begin
        first_d      = (!locked && v_fall) ? 1'b1 : (locked && h_fall) ? 1'b0 : first_q;
        clk_cnt_d    = h_fall ? 12'd1 : (clk_cnt_q == 12'hFFF) ? clk_cnt_q : clk_cnt_q + 12'd1;
        hsw_cnt_d    = hs_q ? 12'd0 : (hsw_cnt_q == 12'hFFF) ? hsw_cnt_q : hsw_cnt_q + 12'd1;
        line_cnt_d   = v_fall ? 11'd0 : lines_closed;
        vsw_cnt_d    = vs_q ? 11'd0 : (h_fall && vsw_cnt_q != 11'h7FF) ? vsw_cnt_q + 11'd1 : vsw_cnt_q;
        line_len_d   = h_chk ? clk_cnt_q : line_len_q;
        frame_len_d  = v_chk ? lines_closed : frame_len_q;
        frame_done_d = v_chk;
        frame_cnt_d  = frame_cnt_q + 16'(v_chk);
        h_err_d      = (h_chk && clk_cnt_q != LINE_L) | (h_err_q & ~mon.ERR_CLR);
        hsw_err_d    = (locked && h_rise && hsw_cnt_q != HSW_L) | (hsw_err_q & ~mon.ERR_CLR);
        v_err_d      = (v_chk && lines_closed != FRAME_L) | (locked && v_rise && vsw_cnt_q != VSW_L)
                     | (v_err_q & ~mon.ERR_CLR);
    end

    // state register and sync edge history; history idles high so reset never fakes an edge
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= ACQUIRE;
            hs_q         <= 1'b1;
            hs_p_q       <= 1'b1;
            vs_q         <= 1'b1;
            vs_p_q       <= 1'b1;
            first_q      <= 1'b0;
            clk_cnt_q    <= '0;
            hsw_cnt_q    <= '0;
            line_cnt_q   <= '0;
            vsw_cnt_q    <= '0;
            line_len_q   <= '0;
            frame_len_q  <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            h_err_q      <= 1'b0;
            hsw_err_q    <= 1'b0;
            v_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_q         <= mon.HSYNC;
            hs_p_q       <= hs_q;
            vs_q         <= mon.VSYNC;
            vs_p_q       <= vs_q;
            first_q      <= first_d;
            clk_cnt_q    <= clk_cnt_d;
            hsw_cnt_q    <= hsw_cnt_d;
            line_cnt_q   <= line_cnt_d;
            vsw_cnt_q    <= vsw_cnt_d;
            line_len_q   <= line_len_d;
            frame_len_q  <= frame_len_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            h_err_q      <= h_err_d;
            hsw_err_q    <= hsw_err_d;
            v_err_q      <= v_err_d;
        end
    end

`ifdef VGA_MON_CHECKSUM_EN
    logic [15:0] acc_q, acc_d, sum_q, sum_d;

    // pixel sum over the visible (both syncs high) cycles, latched when a frame closes
    always_comb begin
        acc_d = (v_chk ? 16'h0000 : acc_q) + ((mon.HSYNC & mon.VSYNC) ? {8'h00, mon.RGB} : 16'h0000);
        sum_d = v_chk ? acc_q : sum_q;
    end

    // checksum accumulator and latched result
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

    assign mon.CHECKSUM = sum_q;
`else
    assign mon.CHECKSUM = 16'h0000;
`endif

    assign mon.LOCKED     = locked;
    assign mon.FRAME_DONE = frame_done_q;
    assign mon.H_ERR      = h_err_q;
    assign mon.HSW_ERR    = hsw_err_q;
    assign mon.V_ERR      = v_err_q;
    assign mon.LINE_LEN   = line_len_q;
    assign mon.FRAME_LEN  = frame_len_q;
    assign mon.FRAME_CNT  = frame_cnt_q;
endmodule
